// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg
// Shared definitions for the run monitor:
//   - state_t          : FSM encoding, also driven out on state_o
//   - HALT_OPC_DEFAULT : opcode that ends a run
//   - DRAIN_W          : width of the post-halt drain counter
//   - opc_field()      : pulls the 6-bit opcode out of an instruction word
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3   // timeout also lands here, flagged separately
  } state_t;

  localparam logic [5:0] HALT_OPC_DEFAULT = 6'b010001;
  localparam int         DRAIN_W          = 8;

  // Opcode extraction kept in one place so every consumer slices the
  // instruction the same way.
  function automatic logic [5:0] opc_field(input logic [63:0] inst, input int lsb);
    logic [63:0] sh;
    sh = inst >> lsb;
    return sh[5:0];
  endfunction

endpackage

// File: rtl/run_monitor_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   reset : synchronous, active low, clears q
//   clr   : synchronous clear, wins over inc
//   inc   : count enable
//   q     : current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/run_monitor.sv
// run_monitor
// Watches the retired-instruction stream of a core and measures one run:
// start launches it, a HALT opcode ends it (after an optional drain
// period waiting for multicycle operations), or a cycle budget expires.
//   clk, reset        : clock, synchronous active-low reset
//   start             : begin a run from IDLE or DONE
//   inst_valid/inst_in: retired instruction stream
//   opr_finished      : drain strobe, drain counter only steps on it
//   state_o           : FSM state (run_monitor_pkg::state_t)
//   done/timeout/busy : registered status flags
//   cycle_cnt/inst_cnt: saturating run statistics
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int          INST_W         = 32,
  parameter int          OPC_LSB        = 26,
  parameter logic [5:0]  HALT_OPC       = HALT_OPC_DEFAULT,
  parameter int          DRAIN_CYCLES   = 6,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          CNT_W          = 32,
  parameter int          GATE_VALID     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] inst_in,
  input  logic              opr_finished,
  output logic [1:0]        state_o,
  output logic              done,
  output logic              timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  inst_cnt
);

  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

  // Timeout compare is done wide so a budget larger than the counter can
  // hold simply never fires instead of aliasing.
  localparam int            TW      = CNT_W + 33;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES) - TW'(1);

  state_t               r_state, w_state_nxt;
  logic [DRAIN_W-1:0]   r_drain, w_drain_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_timeout, w_timeout_nxt;
  logic                 r_busy, w_busy_nxt;

  logic                 w_qual;
  logic                 w_halt;
  logic                 w_drain_step;
  logic                 w_to_hit;
  logic                 w_clr;
  logic                 w_cyc_inc;
  logic                 w_inst_inc;
  logic [CNT_W-1:0]     w_cycle_cnt;
  logic [CNT_W-1:0]     w_inst_cnt;
  logic [TW-1:0]        w_cyc_ext;
  logic [5:0]           w_opc;
  logic                 w_unused_inst;

  // Only the opcode field matters; the rest of the word is intentionally
  // ignored.
  assign w_unused_inst = ^inst_in;

  assign w_opc        = opc_field(64'(inst_in), OPC_LSB);
  assign w_qual       = (GATE_VALID == 0) ? 1'b1 : inst_valid;
  assign w_halt       = w_qual && (w_opc == HALT_OPC);
  assign w_drain_step = opr_finished || (GATE_VALID == 0);

  // Fires on the RUN edge whose incremented count reaches TIMEOUT_CYCLES-1,
  // so the frozen cycle_cnt reads exactly TIMEOUT_CYCLES-1.
  assign w_cyc_ext = TW'(w_cycle_cnt) + TW'(1);
  assign w_to_hit  = (w_cyc_ext >= TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_drain   <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_drain   <= w_drain_nxt;
      r_done    <= w_done_nxt;
      r_timeout <= w_timeout_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_drain_nxt   = r_drain;
    w_done_nxt    = r_done;
    w_timeout_nxt = r_timeout;
    w_clr         = 1'b0;
    w_cyc_inc     = 1'b0;
    w_inst_inc    = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt   = ST_RUN;
          w_clr         = 1'b1;
          w_done_nxt    = 1'b0;
          w_timeout_nxt = 1'b0;
        end
      end

      ST_RUN: begin
        w_cyc_inc  = 1'b1;
        w_inst_inc = w_qual;
        // Halt outranks a coincident timeout.
        if (w_halt) begin
          if (DRAIN_CYCLES == 0) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = DRAIN_INIT;
          end
        end else if (w_to_hit) begin
          w_state_nxt   = ST_DONE;
          w_timeout_nxt = 1'b1;
        end
      end

      ST_DRAIN: begin
        w_cyc_inc = 1'b1;
        if (w_drain_step) begin
          w_drain_nxt = r_drain - DRAIN_W'(1);
          // <= 1 also catches a zero count so DRAIN can never stick.
          if (r_drain <= DRAIN_W'(1)) begin
            w_drain_nxt = '0;
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_cyc_inc),
    .q     (w_cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_inst_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_inst_inc),
    .q     (w_inst_cnt)
  );

  assign state_o   = r_state;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign busy      = r_busy;
  assign cycle_cnt = w_cycle_cnt;
  assign inst_cnt  = w_inst_cnt;

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor
// Four monitors share one stimulus stream: A default, B with a 50-cycle
// budget, C with no drain, D with 4-bit counters. Each task resets, drives
// one scenario and checks the relevant instance against expectations
// derived from the run's length, valid count and drain strobes.
module tb_run_monitor;

  localparam logic [31:0] HALT_W = 32'h4400_0000;

  logic        clk = 1'b0;
  logic        reset, start, inst_valid, opr_finished;
  logic [31:0] inst_in;

  logic [1:0]  a_state, b_state, c_state, d_state;
  logic        a_done, a_to, a_busy, b_done, b_to, b_busy;
  logic        c_done, c_to, c_busy, d_done, d_to, d_busy;
  logic [31:0] a_cyc, a_inst, b_cyc, b_inst, c_cyc, c_inst;
  logic [3:0]  d_cyc, d_inst;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_monitor u_a (
    .clk(clk), .reset(reset), .start(start), .inst_valid(inst_valid),
    .inst_in(inst_in), .opr_finished(opr_finished), .state_o(a_state),
    .done(a_done), .timeout(a_to), .busy(a_busy),
    .cycle_cnt(a_cyc), .inst_cnt(a_inst));

  run_monitor #(.TIMEOUT_CYCLES(50)) u_b (
    .clk(clk), .reset(reset), .start(start), .inst_valid(inst_valid),
    .inst_in(inst_in), .opr_finished(opr_finished), .state_o(b_state),
    .done(b_done), .timeout(b_to), .busy(b_busy),
    .cycle_cnt(b_cyc), .inst_cnt(b_inst));

  run_monitor #(.DRAIN_CYCLES(0)) u_c (
    .clk(clk), .reset(reset), .start(start), .inst_valid(inst_valid),
    .inst_in(inst_in), .opr_finished(opr_finished), .state_o(c_state),
    .done(c_done), .timeout(c_to), .busy(c_busy),
    .cycle_cnt(c_cyc), .inst_cnt(c_inst));

  run_monitor #(.CNT_W(4)) u_d (
    .clk(clk), .reset(reset), .start(start), .inst_valid(inst_valid),
    .inst_in(inst_in), .opr_finished(opr_finished), .state_o(d_state),
    .done(d_done), .timeout(d_to), .busy(d_busy),
    .cycle_cnt(d_cyc), .inst_cnt(d_inst));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_nonhalt();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'b010001) w[26] = ~w[26];
    return w;
  endfunction

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; inst_valid = 1'b0;
    inst_in = '0; opr_finished = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1; inst_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; inst_valid = 1'b1; inst_in = HALT_W; opr_finished = 1'b1;
    tick(); tick();
    checks++;
    if ({a_state, a_done, a_to, a_busy} !== 5'b00000) begin
      errs++; $display("FAIL reset_flags got %b exp %b", {a_state, a_done, a_to, a_busy}, 5'b00000);
    end
    checks++;
    if ({a_cyc, a_inst} !== 64'd0) begin
      errs++; $display("FAIL reset_counters got cyc=%0d inst=%0d exp 0/0", a_cyc, a_inst);
    end
    start = 1'b0; inst_valid = 1'b0; reset = 1'b1;
  endtask

  task automatic test_halt_run();
    do_reset();
    pulse_start();
    checks++;
    if ({a_state, a_busy, a_cyc, a_inst} !== {2'd1, 1'b1, 32'd0, 32'd0}) begin
      errs++; $display("FAIL start_entry got st=%0d busy=%0d cyc=%0d inst=%0d exp 1/1/0/0", a_state, a_busy, a_cyc, a_inst);
    end
    for (int i = 0; i < 10; i++) begin
      inst_valid = 1'b1; inst_in = rand_nonhalt(); tick();
    end
    inst_in = HALT_W; tick();
    inst_valid = 1'b0; inst_in = '0;
    checks++;
    if ({a_state, a_cyc, a_inst} !== {2'd2, 32'd11, 32'd11}) begin
      errs++; $display("FAIL halt_to_drain got st=%0d cyc=%0d inst=%0d exp 2/11/11", a_state, a_cyc, a_inst);
    end
    opr_finished = 1'b1;
    repeat (5) tick();
    checks++;
    if (a_state !== 2'd2) begin
      errs++; $display("FAIL drain_len got st=%0d exp 2", a_state);
    end
    tick();
    opr_finished = 1'b0;
    checks++;
    if ({a_state, a_done, a_to, a_busy, a_cyc, a_inst} !== {2'd3, 1'b1, 1'b0, 1'b0, 32'd17, 32'd11}) begin
      errs++; $display("FAIL halt_done got st=%0d done=%0d to=%0d busy=%0d cyc=%0d inst=%0d exp 3/1/0/0/17/11",
                       a_state, a_done, a_to, a_busy, a_cyc, a_inst);
    end
    inst_valid = 1'b1; inst_in = rand_nonhalt();
    repeat (3) tick();
    inst_valid = 1'b0;
    checks++;
    if ({a_cyc, a_inst, a_done} !== {32'd17, 32'd11, 1'b1}) begin
      errs++; $display("FAIL done_frozen got cyc=%0d inst=%0d done=%0d exp 17/11/1", a_cyc, a_inst, a_done);
    end
  endtask

  task automatic test_gate_valid();
    do_reset();
    pulse_start();
    inst_valid = 1'b0; inst_in = HALT_W;
    repeat (5) tick();
    checks++;
    if ({a_state, a_cyc, a_inst} !== {2'd1, 32'd5, 32'd0}) begin
      errs++; $display("FAIL gated_halt got st=%0d cyc=%0d inst=%0d exp 1/5/0", a_state, a_cyc, a_inst);
    end
    // start inside RUN must not restart the counters
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({a_state, a_cyc} !== {2'd1, 32'd6}) begin
      errs++; $display("FAIL start_in_run got st=%0d cyc=%0d exp 1/6", a_state, a_cyc);
    end
  endtask

  task automatic test_random_runs();
    do_reset();
    for (int it = 0; it < 6; it++) begin
      int len, nvalid, strobes, d;
      len = $urandom_range(1, 30);
      nvalid = 0;
      pulse_start();
      checks++;
      if ({a_state, a_done, a_cyc, a_inst} !== {2'd1, 1'b0, 32'd0, 32'd0}) begin
        errs++; $display("FAIL rnd_restart it=%0d got st=%0d done=%0d cyc=%0d inst=%0d exp 1/0/0/0",
                         it, a_state, a_done, a_cyc, a_inst);
      end
      for (int k = 1; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          inst_in = HALT_W; inst_valid = 1'b0;
        end else begin
          inst_in = rand_nonhalt(); inst_valid = 1'($urandom_range(0, 1));
        end
        if (inst_valid) nvalid++;
        tick();
      end
      inst_in = HALT_W; inst_valid = 1'b1; tick();
      checks++;
      if ({a_state, a_cyc, a_inst} !== {2'd2, 32'(len), 32'(nvalid + 1)}) begin
        errs++; $display("FAIL rnd_halt it=%0d got st=%0d cyc=%0d inst=%0d exp 2/%0d/%0d",
                         it, a_state, a_cyc, a_inst, len, nvalid + 1);
      end
      strobes = 0; d = 0;
      while (strobes < 6 && d < 200) begin
        opr_finished = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        inst_valid = 1'b1; inst_in = $urandom;
        tick();
        d++;
        if (opr_finished) strobes++;
        checks++;
        if (a_state !== ((strobes == 6) ? 2'd3 : 2'd2)) begin
          errs++; $display("FAIL rnd_drain it=%0d step=%0d got st=%0d exp %0d",
                           it, d, a_state, (strobes == 6) ? 3 : 2);
        end
      end
      start = 1'b0; opr_finished = 1'b0; inst_valid = 1'b0;
      checks++;
      if ({a_done, a_to, a_busy, a_cyc, a_inst} !== {1'b1, 1'b0, 1'b0, 32'(len + d), 32'(nvalid + 1)}) begin
        errs++; $display("FAIL rnd_done it=%0d got done=%0d to=%0d busy=%0d cyc=%0d inst=%0d exp 1/0/0/%0d/%0d",
                         it, a_done, a_to, a_busy, a_cyc, a_inst, len + d, nvalid + 1);
      end
    end
  endtask

  task automatic test_timeout();
    int n, nvalid;
    do_reset();
    pulse_start();
    n = 0; nvalid = 0;
    while (b_state == 2'd1 && n < 100) begin
      inst_valid = 1'($urandom_range(0, 1)); inst_in = rand_nonhalt();
      if (inst_valid) nvalid++;
      tick();
      n++;
    end
    inst_valid = 1'b0;
    checks++;
    if (n !== 49) begin
      errs++; $display("FAIL timeout_edge got %0d edges exp 49", n);
    end
    checks++;
    if ({b_state, b_to, b_done, b_busy, b_cyc, b_inst} !== {2'd3, 1'b1, 1'b0, 1'b0, 32'd49, 32'(nvalid)}) begin
      errs++; $display("FAIL timeout_state got st=%0d to=%0d done=%0d busy=%0d cyc=%0d inst=%0d exp 3/1/0/0/49/%0d",
                       b_state, b_to, b_done, b_busy, b_cyc, b_inst, nvalid);
    end
  endtask

  task automatic test_halt_vs_timeout();
    do_reset();
    pulse_start();
    inst_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      inst_in = rand_nonhalt(); tick();
    end
    inst_in = HALT_W; tick();
    inst_valid = 1'b0;
    checks++;
    if ({b_state, b_to, b_cyc, b_inst} !== {2'd2, 1'b0, 32'd49, 32'd49}) begin
      errs++; $display("FAIL halt_beats_timeout got st=%0d to=%0d cyc=%0d inst=%0d exp 2/0/49/49",
                       b_state, b_to, b_cyc, b_inst);
    end
    opr_finished = 1'b1;
    repeat (6) tick();
    opr_finished = 1'b0;
    checks++;
    if ({b_state, b_done, b_to, b_cyc} !== {2'd3, 1'b1, 1'b0, 32'd55}) begin
      errs++; $display("FAIL late_halt_done got st=%0d done=%0d to=%0d cyc=%0d exp 3/1/0/55",
                       b_state, b_done, b_to, b_cyc);
    end
  endtask

  task automatic test_reset_drain();
    do_reset();
    pulse_start();
    inst_valid = 1'b1; inst_in = HALT_W; tick();
    inst_valid = 1'b0; opr_finished = 1'b0;
    tick(); tick();
    checks++;
    if (a_state !== 2'd2) begin
      errs++; $display("FAIL drain_hold got st=%0d exp 2", a_state);
    end
    reset = 1'b0; start = 1'b1; tick();
    checks++;
    if ({a_state, a_busy, a_done, a_to, a_cyc, a_inst} !== {2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0}) begin
      errs++; $display("FAIL reset_in_drain got st=%0d busy=%0d done=%0d to=%0d cyc=%0d inst=%0d exp all 0",
                       a_state, a_busy, a_done, a_to, a_cyc, a_inst);
    end
    tick();
    reset = 1'b1; start = 1'b0; opr_finished = 1'b1; tick();
    opr_finished = 1'b0;
    checks++;
    if ({a_state, a_done, a_to} !== {2'd0, 1'b0, 1'b0}) begin
      errs++; $display("FAIL post_reset_idle got st=%0d done=%0d to=%0d exp 0/0/0", a_state, a_done, a_to);
    end
  endtask

  task automatic test_drain0();
    do_reset();
    pulse_start();
    inst_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_in = rand_nonhalt(); tick();
    end
    inst_in = HALT_W; tick();
    inst_valid = 1'b0;
    checks++;
    if ({c_state, c_done, c_busy, c_cyc, c_inst} !== {2'd3, 1'b1, 1'b0, 32'd4, 32'd4}) begin
      errs++; $display("FAIL drain0_done got st=%0d done=%0d busy=%0d cyc=%0d inst=%0d exp 3/1/0/4/4",
                       c_state, c_done, c_busy, c_cyc, c_inst);
    end
    pulse_start();
    checks++;
    if ({c_state, c_done, c_busy, c_cyc, c_inst} !== {2'd1, 1'b0, 1'b1, 32'd0, 32'd0}) begin
      errs++; $display("FAIL drain0_restart got st=%0d done=%0d busy=%0d cyc=%0d inst=%0d exp 1/0/1/0/0",
                       c_state, c_done, c_busy, c_cyc, c_inst);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    pulse_start();
    inst_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      inst_in = rand_nonhalt(); tick();
    end
    inst_valid = 1'b0;
    checks++;
    if ({d_state, d_inst, d_cyc, d_to} !== {2'd1, 4'd15, 4'd15, 1'b0}) begin
      errs++; $display("FAIL saturate got st=%0d inst=%0d cyc=%0d to=%0d exp 1/15/15/0",
                       d_state, d_inst, d_cyc, d_to);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; inst_valid = 1'b0; inst_in = '0; opr_finished = 1'b0;
    test_reset();
    test_halt_run();
    test_gate_valid();
    test_random_runs();
    test_timeout();
    test_halt_vs_timeout();
    test_reset_drain();
    test_drain0();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
